mem_responder: RTL
==================

# mem_responder

Memory-side responder for the processor's address/data path: accepts a latched 13-bit word address plus a read or write command, holds an on-chip word array, and returns read data or a write acknowledge after a programmable number of wait states. It sits between the memory address/data registers on the processor side and the storage array. It turns single-cycle request strobes into a busy/response handshake.

## Interface
Parameters:
- ADDR_W, 13, address width; matches the memory address register width
- DATA_W, 16, data word width
- DEPTH, 8192, number of words in the array; 1..2^ADDR_W
- WAIT_CYCLES, 2, wait states inserted before the array access; 0..15

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  1  request strobe; sampled only while busy=0
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  word address; sampled with req
- wdata  in  DATA_W  write data; sampled with req
- busy  out  1  request in progress; req ignored while high
- rvalid  out  1  one-cycle pulse: rdata valid for a read
- rdata  out  DATA_W  read data; holds last read value between reads
- done  out  1  one-cycle pulse: write completed
- err  out  1  one-cycle pulse with rvalid/done on an out-of-range access (see Configuration)

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: busy=0. On an edge with req=1, capture addr/we/wdata into internal registers, load wait counter with WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, otherwise ACCESS.
- WAIT: busy=1. Counter decrements each edge; goes to ACCESS on the edge where the counter reaches 0.
- ACCESS: busy=1. On the exiting edge, read: rdata <= array[addr], rvalid <= 1. Write: array[addr] <= wdata, done <= 1. Next state is RESP.
- RESP: busy=1, rvalid or done high for exactly this cycle. On the exiting edge, pulses clear, state goes to IDLE, busy goes to 0.
- req, we, addr, and wdata are don't-care outside the IDLE sampling edge. Captured values are used, so changing inputs mid-transaction has no effect.
- Array contents are not cleared by reset.

## Timing
- Let E0 be the edge at which req is accepted. busy is high from E0 through E0+W+2, where W = WAIT_CYCLES.
- rvalid/done/err are asserted after edge E0+W+1 and deasserted after edge E0+W+2.
- Earliest next accepted request is at edge E0+W+2, when req=1 is held high.
- Back-to-back throughput is one transaction per W+2 cycles.
- Read-after-write to the same address returns the newly written data.
- Reset values: busy=0, rvalid=0, done=0, err=0, rdata=0, state=IDLE, counter=0.
- Reset mid-operation returns to IDLE immediately and produces no pulse.
  - If reset asserts before the ACCESS exit edge, the write is not performed.
  - A write already committed at the ACCESS edge remains.

## Configuration
- MEM_RESP_BOUNDS_CHECK_EN defined:
  - An access with addr >= DEPTH does not touch the array.
  - err pulses in the RESP cycle, together with rvalid (read, rdata forced to 0) or done (write).
  - In-range accesses keep err=0.
- Not defined:
  - err is tied to 0.
  - The array index is addr modulo DEPTH. DEPTH must be a power of two; an elaboration check enforces this.

## Test plan
- Reset, then release with no req → busy=0, rvalid=0, done=0, err=0, rdata=0 for 10 cycles.
- W=2: write 0xBEEF to 0x0123, then read 0x0123 → done one cycle, 3 edges after acceptance; rvalid one cycle, 3 edges after read acceptance, with rdata=0xBEEF. busy spans 4 cycles per transaction.
- W=0: read 0x1FFF with req held high continuously → one response every 2 cycles, no missed or duplicated rvalid pulses. Toggling addr while busy does not alter returned data.
- Reset asserted during WAIT of a write of 0x1234 to 0x0010, then read 0x0010 → no done pulse; the read returns the pre-reset contents, not 0x1234.
- With MEM_RESP_BOUNDS_CHECK_EN and DEPTH=4096, read 0x1000 → rvalid=1, err=1, rdata=0. Write to 0x1000 → done=1, err=1, and array[0x000] is unchanged.
- Without the macro, DEPTH=4096: write 0x5A5A to 0x1001, then read 0x0001 → rdata=0x5A5A, err=0.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder. Captures a word address and a
//               read/write command, waits WAIT_CYCLES wait states, accesses
//               an on-chip word array, then returns rvalid (read) or
//               done (write) for one cycle.
//               Optional feature macro: MEM_RESP_BOUNDS_CHECK_EN
//                 defined   - addr >= DEPTH leaves the array untouched,
//                             pulses err, and a read returns 0
//                 undefined - err tied low, index is addr modulo DEPTH
//                             (DEPTH must be a power of two)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 8192,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err
);

  localparam int         c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

  logic                w_in_range;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_mem_we;

`ifdef MEM_RESP_BOUNDS_CHECK_EN
  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

  assign w_in_range = ({1'b0, r_addr} < c_DEPTH);
  assign w_idx      = c_IDX_W'(r_addr);
`else
  assign w_in_range = 1'b1;
  assign w_idx      = c_IDX_W'(r_addr % DEPTH);

  // Modulo indexing reduces to dropping upper address bits only for 2**n.
  generate
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2_check
      $error("mem_responder: DEPTH must be a power of two without bounds checking");
    end
  endgenerate
`endif

  // Writes commit on the ACCESS exit edge; an out-of-range write is dropped.
  assign w_mem_we = (r_state == S_ACCESS) && r_we && w_in_range && !rst;

  // Storage array write port; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  // Request FSM with registered busy/response outputs. The RESP exit edge is
  // also a sampling edge, which gives back-to-back throughput of W+2 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      busy    <= 1'b0;
      rvalid  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_RESP: begin
          rvalid <= 1'b0;
          done   <= 1'b0;
          err    <= 1'b0;
          if (req) begin
            r_addr  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
            r_cnt   <= c_WAIT;
            busy    <= 1'b1;
            r_state <= (c_WAIT != 4'd0) ? S_WAIT : S_ACCESS;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          err     <= ~w_in_range;
          if (r_we) begin
            done <= 1'b1;
          end else begin
            rvalid <= 1'b1;
            rdata  <= w_in_range ? r_mem[w_idx] : '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
